// File: rtl/mac_array_ctrl_pkg.sv
// mac_array_ctrl_pkg: array instruction codes, sequencer state encodings and query-limit helper
package mac_array_ctrl_pkg;
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  function automatic int max_nq(input int addr_w, input int q_base);
    return (1 << addr_w) - q_base;
  endfunction
endpackage

// File: rtl/mac_ctrl_drain.sv
// mac_ctrl_drain: pops psum rows from the output FIFO and writes them to consecutive psum SRAM addresses
module mac_ctrl_drain #(
  parameter int NQ_W    = 6,
  parameter int PADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               active,
  input  logic [NQ_W-1:0]    nq,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               psum_wr,
  output logic [PADDR_W-1:0] psum_addr,
  output logic               drain_done
);
  logic [NQ_W-1:0] pops;
  assign ofifo_rd = active && ofifo_valid && (pops < nq);
  // every pop is written one cycle later, so all rows are stored once no write is pending
  assign drain_done = (pops == nq) && !psum_wr;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pops      <= '0;
      psum_wr   <= 1'b0;
      psum_addr <= '0;
    end else begin
      pops    <= pops + NQ_W'(ofifo_rd);
      psum_wr <= ofifo_rd;
      if (psum_wr) psum_addr <= psum_addr + PADDR_W'(1);
    end
  end
endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: LOAD/EXEC sequencer for the MAC column array with psum drain.
// Define MAC_CTRL_PERF_EN to add the run_cycles busy-cycle counter output.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int COL      = 8,
  parameter int LOAD_CYC = COL + 2,
  parameter int ADDR_W   = 6,
  parameter int Q_BASE   = 16,
  parameter int NQ_W     = 6,
  parameter int PADDR_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NQ_W-1:0]    num_q,
  output logic               busy,
  output logic               done,
  output logic               qk_rd,
  output logic [ADDR_W-1:0]  qk_addr,
  output logic [1:0]         inst,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               psum_wr,
  output logic [PADDR_W-1:0] psum_addr
`ifdef MAC_CTRL_PERF_EN
  ,output logic [15:0]       run_cycles
`endif
);
  localparam int CNT_W = NQ_W > $clog2(LOAD_CYC) ? NQ_W : $clog2(LOAD_CYC);
  localparam logic [NQ_W-1:0] NQ_MAX = NQ_W'(max_nq(ADDR_W, Q_BASE));
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [NQ_W-1:0]  nq;
  logic             accept, load_last, exec_last, drain_done;
  assign accept    = (state == S_IDLE) && start;
  assign load_last = cnt == CNT_W'(LOAD_CYC - 1);
  assign exec_last = cnt == CNT_W'(nq) - CNT_W'(1);
  assign busy      = (state == S_LOAD) || (state == S_GAP) || (state == S_EXEC) || (state == S_DRAIN);
  assign done      = state == S_DONE;
  assign qk_rd     = (state == S_LOAD) || (state == S_EXEC);
  assign qk_addr   = state == S_LOAD ? ADDR_W'(cnt) :
                     state == S_EXEC ? ADDR_W'(Q_BASE) + ADDR_W'(cnt) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      nq    <= '0;
      inst  <= INST_IDLE;
    end else begin
      // inst trails the read by one cycle to line up with SRAM read data at the array
      inst <= state == S_LOAD ? INST_LOAD : state == S_EXEC ? INST_EXEC : INST_IDLE;
      case (state)
        S_IDLE: if (start) begin
          nq    <= num_q > NQ_MAX ? NQ_MAX : num_q;
          cnt   <= '0;
          state <= num_q != '0 ? S_LOAD : S_DONE;
        end
        S_LOAD: begin
          cnt <= load_last ? '0 : cnt + CNT_W'(1);
          if (load_last) state <= S_GAP;
        end
        S_GAP: state <= S_EXEC;
        S_EXEC: begin
          cnt <= cnt + CNT_W'(1);
          if (exec_last) state <= S_DRAIN;
        end
        S_DRAIN: if (drain_done) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
  mac_ctrl_drain #(.NQ_W(NQ_W), .PADDR_W(PADDR_W)) u_drain (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .active((state == S_EXEC) || (state == S_DRAIN)),
    .nq(nq),
    .ofifo_valid(ofifo_valid),
    .ofifo_rd(ofifo_rd),
    .psum_wr(psum_wr),
    .psum_addr(psum_addr),
    .drain_done(drain_done)
  );
`ifdef MAC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || accept) run_cycles <= '0;
    else if (busy && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: scoreboard bench for mac_array_ctrl (run_cycles checked when MAC_CTRL_PERF_EN is defined)
module tb_mac_array_ctrl;
  localparam int Q_BASE = 16;
  logic clk = 0, reset = 1, start = 0, ofifo_valid = 0;
  logic [5:0] num_q = 0;
  logic busy, done, qk_rd, ofifo_rd, psum_wr;
  logic [5:0] qk_addr, psum_addr;
  logic [1:0] inst;
`ifdef MAC_CTRL_PERF_EN
  logic [15:0] run_cycles;
`endif
  mac_array_ctrl #(.COL(8), .LOAD_CYC(10), .ADDR_W(6), .Q_BASE(Q_BASE), .NQ_W(6), .PADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .num_q(num_q), .busy(busy), .done(done),
    .qk_rd(qk_rd), .qk_addr(qk_addr), .inst(inst), .ofifo_valid(ofifo_valid),
    .ofifo_rd(ofifo_rd), .psum_wr(psum_wr), .psum_addr(psum_addr)
`ifdef MAC_CTRL_PERF_EN
    , .run_cycles(run_cycles)
`endif
  );
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int addr_obs[$], inst_obs[$], paddr_obs[$], exp_a[$], exp_i[$], exp_p[$];
  int pops, writes, dones, busy_len, done_cyc, writes_at_done, busy_at_done, early_pop, orphan_wr, missed_wr;

  task automatic push_expect(input int nq);
    exp_a.delete(); exp_i.delete(); exp_p.delete();
    for (int i = 0; i < 10; i++) begin exp_a.push_back(i); exp_i.push_back(1); end
    if (nq > 0) exp_i.push_back(0);
    for (int i = 0; i < nq; i++) begin exp_a.push_back(Q_BASE + i); exp_i.push_back(2); exp_p.push_back(i); end
  endtask

  // mode 0: a row is ready after each EXEC; mode 1: same but valid only every other cycle; mode 2: valid stuck high
  task automatic run(input int nqv, input int mode, input bit hold);
    int avail = 0, cyc = 0;
    bit prev_rd = 0, seen_exec = 0, tog = 0;
    addr_obs.delete(); inst_obs.delete(); paddr_obs.delete();
    pops = 0; writes = 0; dones = 0; busy_len = 0; done_cyc = -1; writes_at_done = -1;
    busy_at_done = -1; early_pop = 0; orphan_wr = 0; missed_wr = 0;
    @(negedge clk);
    num_q = nqv[5:0];
    start = 1;
    ofifo_valid = mode == 2;
    while (cyc < 600 && (dones == 0 || cyc < done_cyc + 6)) begin
      @(posedge clk);
      #1;
      if (!hold || dones > 0) start = 0;
      tog = !tog;
      ofifo_valid = mode == 2 ? 1'b1 : (avail > 0 && (mode == 0 || tog));
      #1;
      if (qk_rd) begin
        addr_obs.push_back(int'(qk_addr));
        if (qk_addr >= 6'(Q_BASE)) seen_exec = 1;
      end
      inst_obs.push_back(int'(inst));
      if (busy) busy_len++;
      if (ofifo_rd) begin pops++; if (!seen_exec) early_pop++; end
      if (psum_wr) begin
        writes++;
        paddr_obs.push_back(int'(psum_addr));
        if (!prev_rd) orphan_wr++;
      end else if (prev_rd) missed_wr++;
      if (done) begin
        dones++;
        if (done_cyc < 0) begin done_cyc = cyc; writes_at_done = writes; busy_at_done = int'(busy); end
      end
      avail += (inst == 2'b10 ? 1 : 0) - (ofifo_rd ? 1 : 0);
      prev_rd = ofifo_rd;
      cyc++;
    end
    start = 0;
    ofifo_valid = 0;
    n_vec++;
    if (dones == 0) begin n_err++; $display("FAIL run_timeout nq=%0d: done=0 after %0d cycles, required done pulse", nqv, cyc); end
    while (inst_obs.size() > 0 && inst_obs[0] == 0) void'(inst_obs.pop_front());
    while (inst_obs.size() > 0 && inst_obs[$] == 0) void'(inst_obs.pop_back());
  endtask

  task automatic test_reset;
    reset = 1;
    ofifo_valid = 1;
    start = 1;
    num_q = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, qk_rd, ofifo_rd, psum_wr, inst, qk_addr, psum_addr} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b qk_rd=%b ofifo_rd=%b psum_wr=%b inst=%b qk_addr=%0d psum_addr=%0d, required all 0",
               busy, done, qk_rd, ofifo_rd, psum_wr, inst, qk_addr, psum_addr);
    end
    start = 0;
    ofifo_valid = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_basic;
    push_expect(4);
    run(4, 0, 0);
    n_vec++;
    if (addr_obs.size() !== exp_a.size()) begin n_err++; $display("FAIL t1_addr_count: got %0d reads, required %0d", addr_obs.size(), exp_a.size()); end
    else for (int i = 0; i < exp_a.size(); i++) begin
      n_vec++;
      if (addr_obs[i] !== exp_a[i]) begin n_err++; $display("FAIL t1_qk_addr[%0d]: got %0d, required %0d", i, addr_obs[i], exp_a[i]); end
    end
    n_vec++;
    if (inst_obs.size() !== exp_i.size()) begin n_err++; $display("FAIL t1_inst_len: got %0d, required %0d", inst_obs.size(), exp_i.size()); end
    else for (int i = 0; i < exp_i.size(); i++) begin
      n_vec++;
      if (inst_obs[i] !== exp_i[i]) begin n_err++; $display("FAIL t1_inst[%0d]: got %0d, required %0d", i, inst_obs[i], exp_i[i]); end
    end
    n_vec++;
    if (paddr_obs.size() !== exp_p.size()) begin n_err++; $display("FAIL t1_writes: got %0d, required %0d", paddr_obs.size(), exp_p.size()); end
    else while (exp_p.size() > 0) begin
      n_vec++;
      if (paddr_obs.pop_front() !== exp_p[0]) begin n_err++; $display("FAIL t1_psum_addr: required %0d", exp_p[0]); end
      void'(exp_p.pop_front());
    end
    n_vec++;
    if (pops !== 4) begin n_err++; $display("FAIL t1_pops: got %0d, required 4", pops); end
    n_vec++;
    if (dones !== 1 || writes_at_done !== 4 || busy_at_done !== 0) begin
      n_err++; $display("FAIL t1_done: dones=%0d writes_at_done=%0d busy_at_done=%0d, required 1/4/0", dones, writes_at_done, busy_at_done);
    end
    n_vec++;
    if (orphan_wr + missed_wr + early_pop !== 0) begin
      n_err++; $display("FAIL t1_pop_write_pairing: orphan=%0d missed=%0d early=%0d, required 0", orphan_wr, missed_wr, early_pop);
    end
  endtask

  task automatic test_zero;
    run(0, 2, 0);
    n_vec++;
    if (addr_obs.size() !== 0 || pops !== 0 || writes !== 0) begin
      n_err++; $display("FAIL t2_activity: reads=%0d pops=%0d writes=%0d, required 0/0/0", addr_obs.size(), pops, writes);
    end
    n_vec++;
    if (done_cyc !== 0 || dones !== 1) begin n_err++; $display("FAIL t2_done_timing: done_cyc=%0d dones=%0d, required 0/1", done_cyc, dones); end
    n_vec++;
    if (busy_len !== 0) begin n_err++; $display("FAIL t2_busy: got %0d busy cycles, required 0", busy_len); end
  endtask

  task automatic test_toggle;
    push_expect(3);
    run(3, 1, 0);
    n_vec++;
    if (pops !== 3 || writes !== 3) begin n_err++; $display("FAIL t3_counts: pops=%0d writes=%0d, required 3/3", pops, writes); end
    n_vec++;
    if (orphan_wr + missed_wr !== 0) begin n_err++; $display("FAIL t3_write_follows_pop: orphan=%0d missed=%0d, required 0", orphan_wr, missed_wr); end
    n_vec++;
    if (writes_at_done !== 3 || dones !== 1) begin n_err++; $display("FAIL t3_done_after_writes: writes_at_done=%0d dones=%0d, required 3/1", writes_at_done, dones); end
    while (exp_p.size() > 0 && paddr_obs.size() > 0) begin
      n_vec++;
      if (paddr_obs.pop_front() !== exp_p[0]) begin n_err++; $display("FAIL t3_psum_addr: required %0d", exp_p[0]); end
      void'(exp_p.pop_front());
    end
  endtask

  task automatic test_hold_start;
    push_expect(3);
    run(3, 2, 1);
    n_vec++;
    if (pops !== 3 || writes !== 3) begin n_err++; $display("FAIL t4_extra_pop: pops=%0d writes=%0d, required 3/3", pops, writes); end
    n_vec++;
    if (dones !== 1 || addr_obs.size() !== exp_a.size()) begin
      n_err++; $display("FAIL t4_restart: dones=%0d reads=%0d, required 1/%0d", dones, addr_obs.size(), exp_a.size());
    end
    n_vec++;
    if (early_pop !== 0) begin n_err++; $display("FAIL t4_pop_before_exec: got %0d, required 0", early_pop); end
  endtask

  task automatic test_reset_exec;
    int k = 0;
    @(negedge clk);
    num_q = 6'd4;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    while (inst !== 2'b10 && k < 50) begin @(posedge clk); #1; k++; end
    n_vec++;
    if (k >= 50) begin n_err++; $display("FAIL t5_reach_exec: inst=%b after 50 cycles, required 10", inst); end
    ofifo_valid = 1;
    reset = 1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, qk_rd, ofifo_rd, psum_wr, inst, qk_addr, psum_addr} !== 19'd0) begin
      n_err++;
      $display("FAIL t5_abort: busy=%b done=%b qk_rd=%b ofifo_rd=%b psum_wr=%b inst=%b qk_addr=%0d psum_addr=%0d, required all 0",
               busy, done, qk_rd, ofifo_rd, psum_wr, inst, qk_addr, psum_addr);
    end
    reset = 0;
    ofifo_valid = 0;
    push_expect(2);
    run(2, 0, 0);
    n_vec++;
    if (addr_obs.size() !== exp_a.size()) begin n_err++; $display("FAIL t5_rerun_reads: got %0d, required %0d", addr_obs.size(), exp_a.size()); end
    else for (int i = 0; i < exp_a.size(); i++) begin
      n_vec++;
      if (addr_obs[i] !== exp_a[i]) begin n_err++; $display("FAIL t5_qk_addr[%0d]: got %0d, required %0d", i, addr_obs[i], exp_a[i]); end
    end
    n_vec++;
    if (writes !== 2 || dones !== 1) begin n_err++; $display("FAIL t5_rerun_done: writes=%0d dones=%0d, required 2/1", writes, dones); end
  endtask

  task automatic test_saturate;
    push_expect(48);
    run(63, 0, 0);
    n_vec++;
    if (addr_obs.size() !== 58) begin n_err++; $display("FAIL t6_reads: got %0d, required 58", addr_obs.size()); end
    else begin
      n_vec++;
      if (addr_obs[57] !== 63) begin n_err++; $display("FAIL t6_last_addr: got %0d, required 63", addr_obs[57]); end
    end
    n_vec++;
    if (writes !== 48 || pops !== 48) begin n_err++; $display("FAIL t6_writes: writes=%0d pops=%0d, required 48/48", writes, pops); end
    n_vec++;
    if (inst_obs.size() !== exp_i.size()) begin n_err++; $display("FAIL t6_inst_len: got %0d, required %0d", inst_obs.size(), exp_i.size()); end
    while (exp_p.size() > 0 && paddr_obs.size() > 0) begin
      n_vec++;
      if (paddr_obs.pop_front() !== exp_p[0]) begin n_err++; $display("FAIL t6_psum_addr: required %0d", exp_p[0]); end
      void'(exp_p.pop_front());
    end
`ifdef MAC_CTRL_PERF_EN
    n_vec++;
    if (int'(run_cycles) !== busy_len) begin n_err++; $display("FAIL t6_run_cycles: got %0d, required %0d", run_cycles, busy_len); end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_toggle;
    test_hold_start;
    test_reset_exec;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
